// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef logic port_idx_t;

  localparam int unsigned MAX_LOCK_DEFAULT = 16;

  function automatic port_idx_t other_port(input port_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a 1-bit priority pointer.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_load,
  input  port_idx_t  i_load_ptr,
  output logic [1:0] o_gnt,
  output port_idx_t  o_winner
);

  port_idx_t r_ptr;

  always_comb begin
    o_gnt    = 2'b00;
    o_winner = r_ptr;
    case (i_req)
      2'b01: begin
        o_gnt    = 2'b01;
        o_winner = 1'b0;
      end
      2'b10: begin
        o_gnt    = 2'b10;
        o_winner = 1'b1;
      end
      2'b11: begin
        o_gnt    = r_ptr ? 2'b10 : 2'b01;
        o_winner = r_ptr;
      end
      default: begin
        o_gnt    = 2'b00;
        o_winner = r_ptr;
      end
    endcase
  end

  // An explicit load (forced lock release) takes precedence over the normal rotate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= 1'b0;
    end else if (i_load) begin
      r_ptr <= i_load_ptr;
    end else if (i_upd && (|o_gnt)) begin
      r_ptr <= other_port(o_winner);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: round-robin grant, memory-port mux, 1-cycle completion stage.
// Optional exclusive locking is compiled in with SRAM_ARB_LOCK_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned MAX_LOCK       = MAX_LOCK_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,

  input  logic                        m0_req_i,
  input  logic                        m0_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic                        m0_lock_i,
  output logic                        m0_gnt_o,
  output logic                        m0_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                        m1_req_i,
  input  logic                        m1_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic                        m1_lock_i,
  output logic                        m1_gnt_o,
  output logic                        m1_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                        req_o,
  output logic                        we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0] be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i
);

  logic [1:0] w_req;
  logic [1:0] w_req_arb;
  logic [1:0] w_gnt;
  port_idx_t  w_winner;
  logic       w_upd;
  logic       w_load;
  port_idx_t  w_load_ptr;

  logic       r_rvalid;
  port_idx_t  r_owner;

  // Requests are gated by reset so no grant can escape while rst_i is high.
  assign w_req = {m1_req_i, m0_req_i} & {2{~rst_i}};

`ifdef SRAM_ARB_LOCK_EN
  localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

  logic       r_lock_active;
  port_idx_t  r_lock_owner;
  logic [7:0] r_lock_cnt;
  logic       w_owner_lock;
  logic       w_hold;
  logic       w_gnt_lock;
  logic       w_locked_gnt;
  logic       w_same_owner;
  logic [7:0] w_cnt_next;
  logic       w_release;

  assign w_owner_lock = r_lock_owner ? m1_lock_i : m0_lock_i;
  assign w_hold       = r_lock_active && w_owner_lock;
  assign w_req_arb[0] = w_req[0] && !(w_hold && (r_lock_owner == 1'b1));
  assign w_req_arb[1] = w_req[1] && !(w_hold && (r_lock_owner == 1'b0));

  assign w_gnt_lock   = w_winner ? m1_lock_i : m0_lock_i;
  assign w_locked_gnt = (|w_gnt) && w_gnt_lock;
  assign w_same_owner = r_lock_active && (r_lock_owner == w_winner);
  assign w_cnt_next   = w_same_owner ? (r_lock_cnt + 8'd1) : 8'd1;
  assign w_release    = w_locked_gnt && (w_cnt_next == LP_MAX_LOCK);

  // Locked grants freeze the pointer; a forced release hands priority to the other side.
  assign w_upd      = !w_locked_gnt;
  assign w_load     = w_release;
  assign w_load_ptr = other_port(w_winner);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= 1'b0;
      r_lock_cnt    <= 8'd0;
    end else if (w_locked_gnt) begin
      if (w_release) begin
        r_lock_active <= 1'b0;
        r_lock_cnt    <= 8'd0;
      end else begin
        r_lock_active <= 1'b1;
        r_lock_owner  <= w_winner;
        r_lock_cnt    <= w_cnt_next;
      end
    end else if (r_lock_active && !w_owner_lock) begin
      r_lock_active <= 1'b0;
      r_lock_cnt    <= 8'd0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = m0_lock_i ^ m1_lock_i;
  assign w_req_arb     = w_req;
  assign w_upd         = 1'b1;
  assign w_load        = 1'b0;
  assign w_load_ptr    = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_req      (w_req_arb),
    .i_upd      (w_upd),
    .i_load     (w_load),
    .i_load_ptr (w_load_ptr),
    .o_gnt      (w_gnt),
    .o_winner   (w_winner)
  );

  assign m0_gnt_o = w_gnt[0];
  assign m1_gnt_o = w_gnt[1];

  assign req_o  = |w_gnt;
  assign we_o   = req_o && (w_winner ? m1_we_i : m0_we_i);
  assign addr_o = w_winner ? m1_addr_i  : m0_addr_i;
  assign be_o   = w_winner ? m1_be_i    : m0_be_i;
  assign data_o = w_winner ? m1_wdata_i : m0_wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_owner  <= 1'b0;
    end else begin
      r_rvalid <= |w_gnt;
      r_owner  <= w_winner;
    end
  end

  assign m0_rvalid_o = r_rvalid && (r_owner == 1'b0);
  assign m1_rvalid_o = r_rvalid && (r_owner == 1'b1);
  assign m0_rdata_o  = data_i;
  assign m1_rdata_o  = data_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a small registered SRAM model on the memory side.
module tb_sram_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  typedef struct {
    logic [1:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]    rv;
    logic          rd;
    logic [DW-1:0] rdata;
  } rexp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m0_we_i, m0_lock_i, m0_gnt_o, m0_rvalid_o;
  logic [AW-1:0] m0_addr_i;
  logic [BW-1:0] m0_be_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_rvalid_o;
  logic [AW-1:0] m1_addr_i;
  logic [BW-1:0] m1_be_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          req_o, we_o;
  logic [AW-1:0] addr_o;
  logic [BW-1:0] be_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_i;

  gexp_t gq[$];
  rexp_t rq[$];
  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [8] = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
                             64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003,
                             64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0005,
                             64'hCAFE_0000_0000_0006, 64'hCAFE_0000_0000_0007};
  logic [DW-1:0] r_data_q = '0;

  always #5 clk_i = ~clk_i;

  sram_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_LOCK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_lock_i(m0_lock_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o),
    .data_i(data_i)
  );

  // SRAM model: byte-enabled write, read data registered one cycle after req_o.
  always @(posedge clk_i) begin
    if (req_o) begin
      if (we_o) begin
        for (int b = 0; b < BW; b++)
          if (be_o[b]) mem[addr_o[5:3]][b*8 +: 8] <= data_o[b*8 +: 8];
      end
      r_data_q <= mem[addr_o[5:3]];
    end
  end
  assign data_i = r_data_q;

  always @(negedge clk_i) begin
    gexp_t g;
    rexp_t r;
    logic [DW-1:0] rd_act;
    if (req_o || m0_gnt_o || m1_gnt_o) begin
      vectors++;
      if (gq.size() == 0) begin
        miscompares++;
        $display("FAIL grant: unexpected gnt=%b req_o=%b addr=%h", {m1_gnt_o, m0_gnt_o}, req_o, addr_o);
      end else begin
        g = gq.pop_front();
        if ({m1_gnt_o, m0_gnt_o} !== g.gnt || req_o !== 1'b1 || we_o !== g.we ||
            addr_o !== g.addr || be_o !== g.be || (g.we && data_o !== g.wdata)) begin
          miscompares++;
          $display("FAIL grant: got gnt=%b req=%b we=%b addr=%h be=%h data=%h, expected gnt=%b we=%b addr=%h be=%h data=%h",
                   {m1_gnt_o, m0_gnt_o}, req_o, we_o, addr_o, be_o, data_o,
                   g.gnt, g.we, g.addr, g.be, g.wdata);
        end
      end
    end
    if (m0_rvalid_o || m1_rvalid_o) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL rvalid: unexpected rvalid=%b", {m1_rvalid_o, m0_rvalid_o});
      end else begin
        r = rq.pop_front();
        rd_act = r.rv[1] ? m1_rdata_o : m0_rdata_o;
        if ({m1_rvalid_o, m0_rvalid_o} !== r.rv || (r.rd && rd_act !== r.rdata)) begin
          miscompares++;
          $display("FAIL rvalid: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                   {m1_rvalid_o, m0_rvalid_o}, rd_act, r.rv, r.rdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic lk);
    m0_req_i = req; m0_we_i = we; m0_addr_i = a; m0_be_i = be; m0_wdata_i = wd; m0_lock_i = lk;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic lk);
    m1_req_i = req; m1_we_i = we; m1_addr_i = a; m1_be_i = be; m1_wdata_i = wd; m1_lock_i = lk;
  endtask

  task automatic exp_g(input logic [1:0] gnt, input logic we, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    gexp_t e;
    e.gnt = gnt; e.we = we; e.addr = a; e.be = be; e.wdata = wd;
    gq.push_back(e);
  endtask

  task automatic exp_r(input logic [1:0] rv, input logic rd, input logic [DW-1:0] d);
    rexp_t e;
    e.rv = rv; e.rd = rd; e.rdata = d;
    rq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic both_m0(); exp_g(2'b01, 1'b0, 64'h110, 8'hFF, '0); exp_r(2'b01, 1'b1, 64'hCAFE_0000_0000_0002); endtask
  task automatic both_m1(); exp_g(2'b10, 1'b0, 64'h118, 8'hFF, '0); exp_r(2'b10, 1'b1, 64'hCAFE_0000_0000_0003); endtask

  initial begin
    rst_i = 1'b1;
    set_m0(1'b1, 1'b1, 64'h100, 8'hFF, '0, 1'b0);
    set_m1(1'b1, 1'b1, 64'h108, 8'hFF, '0, 1'b0);
    tick();
    @(negedge clk_i);
    chk("rst_m0_gnt", 64'(m0_gnt_o), 64'd0);
    chk("rst_m1_gnt", 64'(m1_gnt_o), 64'd0);
    chk("rst_req_o", 64'(req_o), 64'd0);
    chk("rst_we_o", 64'(we_o), 64'd0);
    chk("rst_m0_rvalid", 64'(m0_rvalid_o), 64'd0);
    chk("rst_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
    tick();

    // single m0 read
    rst_i = 1'b0;
    set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_m0(1'b1, 1'b0, 64'h100, 8'hFF, '0, 1'b0);
    exp_g(2'b01, 1'b0, 64'h100, 8'hFF, '0);
    exp_r(2'b01, 1'b1, 64'hCAFE_0000_0000_0000);
    tick();

    // single m1 partial write
    set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_m1(1'b1, 1'b1, 64'h100, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1'b0);
    exp_g(2'b10, 1'b1, 64'h100, 8'h0F, 64'h0000_0000_DEAD_BEEF);
    exp_r(2'b10, 1'b0, '0);
    tick();

    // read back merged word
    set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_m0(1'b1, 1'b0, 64'h100, 8'hFF, '0, 1'b0);
    exp_g(2'b01, 1'b0, 64'h100, 8'hFF, '0);
    exp_r(2'b01, 1'b1, 64'hCAFE_0000_DEAD_BEEF);
    tick();

    // grant then reset in the next cycle: completion is dropped
    set_m0(1'b1, 1'b0, 64'h108, 8'hFF, '0, 1'b0);
    exp_g(2'b01, 1'b0, 64'h108, 8'hFF, '0);
    tick();
    rst_i = 1'b1;
    set_m0(1'b1, 1'b0, 64'h110, 8'hFF, '0, 1'b0);
    set_m1(1'b1, 1'b0, 64'h118, 8'hFF, '0, 1'b0);
    @(negedge clk_i);
    chk("midrst_m0_rvalid", 64'(m0_rvalid_o), 64'd0);
    chk("midrst_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
    chk("midrst_gnt", 64'({m1_gnt_o, m0_gnt_o}), 64'd0);
    tick();

    // both requesting after release: m0 first, then alternate
    both_m0(); both_m1(); both_m0(); both_m1();
    rst_i = 1'b0;
    repeat (4) tick();

    // m0 holds lock while both request
`ifdef SRAM_ARB_LOCK_EN
    both_m0(); both_m0(); both_m0(); both_m0(); both_m1();
`else
    both_m0(); both_m1(); both_m0(); both_m1(); both_m0();
`endif
    m0_lock_i = 1'b1;
    repeat (5) tick();

    set_m0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_m1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, memory address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; byte enables are AXI_DATA_WIDTH/8 wide.
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive locked grants, range 1..255.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have, per requester n in {0,1}:
- mn_req_i  in  1  access request.
- mn_we_i  in  1  1 = write, 0 = read.
- mn_addr_i  in  AXI_ADDR_WIDTH  byte address.
- mn_be_i  in  AXI_DATA_WIDTH/8  byte enables.
- mn_wdata_i  in  AXI_DATA_WIDTH  write data.
- mn_lock_i  in  1  hold exclusive ownership.
- mn_gnt_o  out  1  access accepted this cycle.
- mn_rvalid_o  out  1  completion, one cycle after grant.
- mn_rdata_o  out  AXI_DATA_WIDTH  read data.
REQ-006 SHALL have memory-side ports:
- req_o  out  1  memory request.
- we_o  out  1  write enable.
- addr_o  out  AXI_ADDR_WIDTH  address.
- be_o  out  AXI_DATA_WIDTH/8  byte enables.
- data_o  out  AXI_DATA_WIDTH  write data.
- data_i  in  AXI_DATA_WIDTH  read data, valid one cycle after req_o.

Function
REQ-007 Grant SHALL be combinational, with at most one mn_gnt_o high per cycle and mn_gnt_o only when mn_req_i is high.
REQ-008 The memory port SHALL carry the granted requester's we/addr/be/wdata with req_o=1; with no grant, req_o=0, we_o=0 and other outputs are don't-care.
REQ-009 Arbitration SHALL be round-robin with a 1-bit priority pointer:
- a single requester is granted immediately;
- when both request, the pointed-to requester wins;
- after any unlocked grant, the pointer moves to the other requester.
REQ-010 mn_rvalid_o SHALL assert exactly one cycle after every mn_gnt_o, for reads and writes, via a registered 1-bit owner/valid stage.
REQ-011 mn_rdata_o SHALL equal data_i for both ports; it is meaningful only with mn_rvalid_o and a read grant.
REQ-012 Back-to-back grants SHALL give full throughput: one access per cycle, no idle cycle between requesters.

Reset
REQ-013 While rst_i is high:
- all mn_gnt_o, mn_rvalid_o, req_o and we_o SHALL be 0;
- the pointer SHALL be 0 (requester 0 first);
- lock state and the lock counter SHALL be cleared.
REQ-014 Reset asserted mid-operation SHALL drop any pending rvalid; the first grant after release SHALL follow REQ-009 from pointer 0.

Configuration
REQ-015 With SRAM_ARB_LOCK_EN defined, locking SHALL work as follows:
- a grant with mn_lock_i=1 makes requester n owner;
- the other requester SHALL NOT be granted while the owner holds mn_lock_i=1;
- the owner is granted on each cycle it requests;
- a per-owner counter counts locked grants and SHALL force release after MAX_LOCK grants;
- after release, the other requester wins the next contention;
- lock drops when mn_lock_i=0 or on reset;
- the pointer is not updated during locked grants.
REQ-016 With SRAM_ARB_LOCK_EN undefined, mn_lock_i SHALL be ignored and the lock logic not instantiated.

Structure
REQ-017 Package sram_arb_pkg SHALL hold the port-index typedef (1 bit) and the MAX_LOCK default constant.
REQ-018 Sub-module rr_arb2 SHALL hold the 2-way round-robin grant logic and pointer register; sram_arbiter holds the muxing, rvalid stage and lock logic.

Verification
REQ-019 Both idle -> m0 read at 0x100 -> m0_gnt_o=1, addr_o=0x100, we_o=0; next cycle m0_rvalid_o=1 and m0_rdata_o=data_i.
REQ-020 Both request every cycle for 4 cycles after reset -> grants m0,m1,m0,m1; rvalid alternates one cycle later; req_o high all 4 cycles.
REQ-021 m1 write 0xDEADBEEF with be=0x0F, m0 idle -> data_o=0xDEADBEEF, be_o=0x0F, we_o=1; m1_rvalid_o next cycle.
REQ-022 With SRAM_ARB_LOCK_EN and MAX_LOCK=4, m0 locked with both requesting -> 4 m0 grants, then m1 granted.
REQ-023 Without the macro, the REQ-022 stimulus -> grants alternate as in REQ-020.
REQ-024 rst_i asserted the cycle after a grant -> no rvalid; after release, both requesting -> m0 granted first.
